// File: rtl/alu_seq_driver.sv
// Purpose: drives the ALU switch/button operand protocol (load A, B, OP), captures the LED result and checks it against a golden model.
// Latency: start edge to o_done is WAIT_CYC+6 cycles; back-to-back transactions every WAIT_CYC+7 cycles with i_start held.
// Backpressure: none; i_start is only sampled in IDLE, and a request while busy is dropped, not queued.
module alu_seq_driver #(
    parameter int N_BITS   = 6,
    parameter int N_LEDS   = 6,
    parameter int N_B      = 3,
    parameter int WAIT_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic [5:0]        i_op,
    input  logic [N_LEDS-1:0] i_led,
    output logic [N_BITS-1:0] o_SWs,
    output logic [N_B-1:0]    o_buttons,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_LEDS-1:0] o_result,
    output logic              o_match,
    output logic              o_bad_op,
    output logic [7:0]        o_pass_cnt,
    output logic [7:0]        o_fail_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_A, S_PUL_A, S_SET_B, S_PUL_B, S_SET_OP, S_PUL_OP, S_WAIT, S_CAPT
    } state_t;

    // WAIT covers the first WAIT_CYC-1 settle cycles; CAPT is the last one, captured on its exit edge
    localparam int CW = (WAIT_CYC > 2) ? $clog2(WAIT_CYC - 1) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'((WAIT_CYC > 1) ? (WAIT_CYC - 2) : 0);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
    logic [5:0]        op_q, op_d;
    logic [N_BITS-1:0] sws_q, sws_d;
    logic [N_B-1:0]    buttons_q, buttons_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [N_LEDS-1:0] result_q, result_d;
    logic              match_q, match_d, bad_op_q, bad_op_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

    logic [N_BITS-1:0] gold;
    logic              op_ok;
    logic              b_big;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state: fixed walk through the load sequence, then the settle wait
    always_comb begin
        state_d = state_q;
        wcnt_d  = '0;
        case (state_q)
            S_IDLE:   if (i_start) state_d = S_SET_A;
            S_SET_A:  state_d = S_PUL_A;
            S_PUL_A:  state_d = S_SET_B;
            S_SET_B:  state_d = S_PUL_B;
            S_PUL_B:  state_d = S_SET_OP;
            S_SET_OP: state_d = S_PUL_OP;
            S_PUL_OP: state_d = (WAIT_CYC > 1) ? S_WAIT : S_CAPT;
            S_WAIT: begin
                if (wcnt_q == WCNT_LAST) state_d = S_CAPT;
                else                     wcnt_d  = wcnt_q + 1'b1;
            end
            S_CAPT:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Golden model of the ALU for the latched operands
    always_comb begin
        gold  = '0;
        op_ok = 1'b1;
        b_big = (int'(b_q) >= N_BITS);
        case (op_q)
            OP_ADD: gold = a_q + b_q;
            OP_SUB: gold = a_q - b_q;
            OP_AND: gold = a_q & b_q;
            OP_OR:  gold = a_q | b_q;
            OP_XOR: gold = a_q ^ b_q;
            OP_NOR: gold = ~(a_q | b_q);
            OP_SRA: gold = b_big ? {N_BITS{a_q[N_BITS-1]}} : $unsigned($signed(a_q) >>> b_q);
            OP_SRL: gold = b_big ? '0 : (a_q >> b_q);
            default: op_ok = 1'b0;
        endcase
    end

    // Output values for the next cycle, keyed on the state being entered
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sws_d      = sws_q;
        buttons_d  = '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = 1'b0;
        result_d   = result_q;
        match_d    = match_q;
        bad_op_d   = bad_op_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;

        if (state_q == S_IDLE && i_start) begin
            a_d  = i_a;
            b_d  = i_b;
            op_d = i_op;
        end

        case (state_d)
            S_SET_A:  sws_d = a_d;
            S_PUL_A:  begin sws_d = a_q; buttons_d = N_B'(3'b100); end
            S_SET_B:  sws_d = b_q;
            S_PUL_B:  begin sws_d = b_q; buttons_d = N_B'(3'b010); end
            S_SET_OP: sws_d = N_BITS'(op_q);
            S_PUL_OP: begin sws_d = N_BITS'(op_q); buttons_d = N_B'(3'b001); end
            S_WAIT, S_CAPT: sws_d = N_BITS'(op_q);
            default: ;
        endcase

        if (state_q == S_CAPT) begin
            done_d   = 1'b1;
            result_d = i_led;
            bad_op_d = ~op_ok;
            match_d  = op_ok && (i_led == N_LEDS'(gold));
            if (op_ok && match_d && pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
            if (op_ok && !match_d && fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
        end
    end

    // Output and operand registers
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sws_q      <= '0;
            buttons_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            match_q    <= 1'b0;
            bad_op_q   <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sws_q      <= sws_d;
            buttons_q  <= buttons_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            match_q    <= match_d;
            bad_op_q   <= bad_op_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign o_SWs      = sws_q;
    assign o_buttons  = buttons_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_match    = match_q;
    assign o_bad_op   = bad_op_q;
    assign o_pass_cnt = pass_cnt_q;
    assign o_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Purpose: randomized and directed bench for alu_seq_driver against a stand-in ALU and an arithmetic reference.
// Latency: expects o_done WAIT+6 cycles after the start edge.
// Backpressure: none; checks that requests while busy are dropped.
module tb_alu_seq_driver;

    localparam int NB   = 6;
    localparam int WAIT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_start;
    logic [NB-1:0] i_a, i_b;
    logic [5:0]    i_op;
    logic [NB-1:0] i_led;
    logic [NB-1:0] o_SWs;
    logic [2:0]    o_buttons;
    logic          o_busy, o_done, o_match, o_bad_op;
    logic [NB-1:0] o_result;
    logic [7:0]    o_pass_cnt, o_fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    logic alu_fault = 1'b0;

    alu_seq_driver #(.N_BITS(NB), .N_LEDS(NB), .N_B(3), .WAIT_CYC(WAIT)) dut (
        .clock(clock), .reset(reset), .i_start(i_start),
        .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_led(i_led),
        .o_SWs(o_SWs), .o_buttons(o_buttons), .o_busy(o_busy), .o_done(o_done),
        .o_result(o_result), .o_match(o_match), .o_bad_op(o_bad_op),
        .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt)
    );

    always #5 clock = ~clock;

    // Reference ALU result from the opcode table, using plain integer arithmetic
    function automatic int ref_alu(input int a, input int b, input int op);
        int sa;
        case (op)
            32'h20: return (a + b) % 64;
            32'h22: return (a - b + 64) % 64;
            32'h24: return a & b;
            32'h25: return a | b;
            32'h26: return a ^ b;
            32'h27: return 63 - (a | b);
            32'h03: begin
                if (b >= NB) return (a >= 32) ? 63 : 0;
                sa = (a >= 32) ? a - 64 : a;
                return (sa >>> b) & 63;
            end
            32'h02: return (b >= NB) ? 0 : (a >> b);
            default: return 0;
        endcase
    endfunction

    function automatic bit op_valid(input int op);
        return op == 32'h20 || op == 32'h22 || op == 32'h24 || op == 32'h25 ||
               op == 32'h26 || op == 32'h27 || op == 32'h03 || op == 32'h02;
    endfunction

    // Stand-in ALU: registers loaded by button pulses, LEDs show the function of them
    logic [NB-1:0] alu_a, alu_b;
    logic [5:0]    alu_op;
    always @(posedge clock) begin
        if (reset) begin
            alu_a <= '0; alu_b <= '0; alu_op <= '0;
        end else begin
            if (o_buttons[2]) alu_a  <= o_SWs;
            if (o_buttons[1]) alu_b  <= o_SWs;
            if (o_buttons[0]) alu_op <= o_SWs;
        end
    end
    assign i_led = alu_fault ? '0 : NB'(ref_alu(int'(alu_a), int'(alu_b), int'(alu_op)));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full transaction; pulse_at>0 re-raises i_start just before edge k+pulse_at
    task automatic run_txn(input int a, input int b, input int op, input int lit, input int pulse_at);
        int exp_btn[6] = '{0, 4, 0, 2, 0, 1};
        int exp_sws[6];
        int cyc;
        int res;
        bit ok;
        exp_sws = '{a, a, b, b, op, op};
        i_a = NB'(a); i_b = NB'(b); i_op = 6'(op); i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
        i_a = NB'($urandom); i_b = NB'($urandom); i_op = 6'($urandom);
        chk("busy_at_start", int'(o_busy), 1);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) begin
                i_start = (pulse_at == j);
                @(posedge clock); #1;
            end
            chk($sformatf("buttons_k+%0d", j), int'(o_buttons), exp_btn[j]);
            chk($sformatf("sws_k+%0d", j), int'(o_SWs), exp_sws[j]);
        end
        i_start = 1'b0;
        cyc = 5;
        while (!o_done && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("latency", cyc, 6 + WAIT);
        ok  = op_valid(op);
        res = (alu_fault || !ok) ? 0 : ref_alu(a, b, op);
        if (ok && res == ref_alu(a, b, op)) begin
            if (exp_pass < 255) exp_pass++;
        end else if (ok) begin
            if (exp_fail < 255) exp_fail++;
        end
        chk("result", int'(o_result), res);
        if (lit >= 0) chk("result_literal", int'(o_result), lit);
        chk("match", int'(o_match), int'(ok && res == ref_alu(a, b, op)));
        chk("bad_op", int'(o_bad_op), int'(!ok));
        chk("busy_at_done", int'(o_busy), 0);
        chk("pass_cnt", int'(o_pass_cnt), exp_pass);
        chk("fail_cnt", int'(o_fail_cnt), exp_fail);
        @(posedge clock); #1;
        chk("done_pulse", int'(o_done), 0);
        chk("idle_after", int'(o_busy), 0);
        chk("match_held", int'(o_match), int'(ok && res == ref_alu(a, b, op)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops[8] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h03, 32'h02, 32'h27};
        int last_done, cyc, gap_bad, sat_fail;

        // Reset with a start request asserted throughout
        reset = 1'b1; i_start = 1'b1; i_a = 6'd9; i_b = 6'd4; i_op = 6'h20;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_sws", int'(o_SWs), 0);
        chk("rst_buttons", int'(o_buttons), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_result", int'(o_result), 0);
        chk("rst_match", int'(o_match), 0);
        chk("rst_bad_op", int'(o_bad_op), 0);
        chk("rst_pass", int'(o_pass_cnt), 0);
        chk("rst_fail", int'(o_fail_cnt), 0);
        reset = 1'b0; i_start = 1'b0;
        @(posedge clock); #1;
        chk("rst_start_ignored", int'(o_busy), 0);

        // Directed arithmetic cases
        run_txn(5, 3, 32'h20, 8, 0);
        run_txn(3, 5, 32'h22, 62, 0);
        run_txn(32, 2, 32'h03, 56, 0);
        run_txn(32, 2, 32'h02, 8, 0);
        run_txn(32, 7, 32'h03, 63, 0);
        run_txn(0, 0, 32'h27, 63, 0);
        run_txn(12, 40, 32'h02, 0, 0);

        // Faulty ALU and unsupported opcode
        alu_fault = 1'b1;
        run_txn(1, 1, 32'h20, 0, 0);
        alu_fault = 1'b0;
        run_txn(7, 9, 32'h3F, -1, 0);

        // Start re-requested while busy is dropped
        run_txn(21, 13, 32'h26, 24, 3);

        // Reset in the middle of a transaction
        i_a = 6'd10; i_b = 6'd20; i_op = 6'h20; i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_buttons", int'(o_buttons), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_sws", int'(o_SWs), 0);
        chk("midrst_pass", int'(o_pass_cnt), 0);
        chk("midrst_fail", int'(o_fail_cnt), 0);
        exp_pass = 0; exp_fail = 0;
        @(posedge clock); #1;
        chk("midrst_idle", int'(o_busy), 0);
        chk("midrst_no_pulse", int'(o_buttons), 0);
        run_txn(10, 20, 32'h20, 30, 0);

        // Randomized transactions, occasional unsupported opcode
        for (int t = 0; t < 30; t++) begin
            int op;
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            run_txn(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), op, -1, 0);
        end

        // Back-to-back with i_start held: spacing and counter saturation
        i_a = 6'd5; i_b = 6'd3; i_op = 6'h20; i_start = 1'b1;
        last_done = -1; cyc = 0; gap_bad = 0; sat_fail = 0;
        for (int n = 0; n < 260; n++) begin
            int budget;
            budget = 0;
            do begin
                @(posedge clock); #1;
                cyc++; budget++;
            end while (!o_done && budget < 40);
            if (n == 259) i_start = 1'b0;
            if (!o_done) sat_fail++;
            if (!o_match) sat_fail++;
            if (last_done >= 0 && cyc - last_done != WAIT + 7) gap_bad++;
            last_done = cyc;
        end
        chk("b2b_spacing_errors", gap_bad, 0);
        chk("b2b_done_match_errors", sat_fail, 0);
        chk("pass_saturated", int'(o_pass_cnt), 255);
        chk("fail_after_sat", int'(o_fail_cnt), exp_fail);
        @(posedge clock); #1;
        chk("b2b_stop", int'(o_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
